// File: rtl/l2_cache_ctrl.sv
// l2_cache_ctrl: request sequencer sitting directly in front of the L2 array.
// Resolves hits in the array, writes back dirty victims, fills missing lines
// from main memory and returns one response per accepted request.
// Optional hit/miss/writeback counters are compiled in with L2_STATS_EN.
module l2_cache_ctrl #(
  parameter int TAG_W  = 51,
  parameter int IDX_W  = 7,
  parameter int OFF_W  = 6,
  parameter int LINE_W = 512,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  // L1-side request / response
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LINE_W-1:0] rsp_data,
  output logic              rsp_err,
  // L2 array
  output logic              c_enable,
  output logic              c_comp,
  output logic              c_write,
  output logic              c_valid_in,
  output logic [TAG_W-1:0]  c_tag_in,
  output logic [IDX_W-1:0]  c_index,
  output logic [OFF_W-1:0]  c_offset,
  output logic [LINE_W-1:0] c_data_in,
  input  logic [TAG_W-1:0]  c_tag_out,
  input  logic [LINE_W-1:0] c_data_out,
  input  logic              c_hit,
  input  logic              c_dirty,
  input  logic              c_valid,
  input  logic              c_err,
  // main memory
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data
`ifdef L2_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_writebacks
`endif
);

  typedef enum logic [3:0] {
    IDLE, COMP, VICT, WB_REQ, FILL_REQ, FILL_WAIT, FILL_WR, RETRY, RESP, ERR
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] line_q;   // victim line, then fill line / read-hit line
  logic [TAG_W-1:0]  vtag_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic              hit;
  logic              unused_in;

  assign tag_q     = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_q     = addr_q[OFF_W +: IDX_W];
  assign hit       = c_hit & c_valid;
  // The array error flag has no defined reaction in this controller.
  assign unused_in = c_err;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Request latch and line buffer; the buffer is reused victim -> fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      line_q  <= '0;
      vtag_q  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          write_q <= req_write;
          wdata_q <= req_wdata;
        end
        COMP:      if (hit && !write_q) line_q <= c_data_out;
        VICT: begin
          vtag_q <= c_tag_out;
          line_q <= c_data_out;
        end
        FILL_WAIT: if (mem_rsp_valid) line_q <= mem_rsp_data;
        default: ;
      endcase
    end
  end

  // Next-state and all handshake / array / memory outputs.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_err       = 1'b0;
    c_enable      = 1'b0;
    c_comp        = 1'b0;
    c_write       = 1'b0;
    c_valid_in    = 1'b0;
    c_tag_in      = tag_q;
    c_index       = idx_q;
    c_offset      = '0;
    c_data_in     = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nxt = (req_addr[OFF_W-1:0] != '0) ? ERR : COMP;
      end
      COMP: begin
        c_enable  = 1'b1;
        c_comp    = 1'b1;
        c_write   = write_q;
        c_data_in = wdata_q;
        if (hit)                  state_nxt = RESP;
        else if (c_valid && c_dirty) state_nxt = VICT;
        else                      state_nxt = FILL_REQ;
      end
      VICT: begin
        c_enable  = 1'b1;
        state_nxt = WB_REQ;
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {vtag_q, idx_q, {OFF_W{1'b0}}};
        mem_req_wdata = line_q;
        if (mem_req_ready) state_nxt = FILL_REQ;
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_q, idx_q, {OFF_W{1'b0}}};
        if (mem_req_ready) state_nxt = FILL_WAIT;
      end
      FILL_WAIT: if (mem_rsp_valid) state_nxt = FILL_WR;
      FILL_WR: begin
        c_enable   = 1'b1;
        c_write    = 1'b1;
        c_valid_in = 1'b1;
        c_data_in  = line_q;
        state_nxt  = write_q ? RETRY : RESP;
      end
      RETRY: begin
        c_enable  = 1'b1;
        c_comp    = 1'b1;
        c_write   = 1'b1;
        c_data_in = wdata_q;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // While reset is held nothing may handshake or touch the array.
    if (!rst) begin
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      c_enable      = 1'b0;
      c_write       = 1'b0;
      mem_req_valid = 1'b0;
    end
  end

  // Reads return the buffered line; writes and errors return zero.
  always_comb begin
    rsp_data = '0;
    if (state == RESP && !write_q) rsp_data = line_q;
  end

`ifdef L2_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (state == COMP && hit && stat_hits != '1)
        stat_hits <= stat_hits + 32'd1;
      if (state == COMP && !hit && stat_misses != '1)
        stat_misses <= stat_misses + 32'd1;
      if (state == WB_REQ && mem_req_ready && stat_writebacks != '1)
        stat_writebacks <= stat_writebacks + 32'd1;
    end
  end
`endif

endmodule

// File: doc/l2_cache_ctrl.md
Name: l2_cache_ctrl

Overview:
- Sequencing FSM directly upstream of the L2 cache array. It drives the array's enable/comp/write/tag/index/offset/data/valid_in inputs and consumes tag_out/data_out/hit/dirty/valid/err.
- Accepts one 64B-line read or write request at a time from the L1 side. It resolves hits in the array, performs dirty-victim writeback and line fill through a main-memory port, then returns a response.

Parameters:
- TAG_W, 51, tag width (L2_TAG_WIDTH)
- IDX_W, 7, index width (L2_INDEX_WIDTH)
- OFF_W, 6, byte offset width (L2_OFFSET_WIDTH)
- LINE_W, 512, line data width (DATA_WIDTH)
- ADDR_W, 64, request address width; must equal TAG_W+IDX_W+OFF_W

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&req_ready
- req_write  in  1  1=line write, 0=line read
- req_addr  in  ADDR_W  byte address {tag,index,offset}
- req_wdata  in  LINE_W  write line
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  LINE_W  read line (0 for writes and errors)
- rsp_err  out  1  misaligned request
- c_enable, c_comp, c_write, c_valid_in  out  1 each  cache controls
- c_tag_in  out  TAG_W;  c_index  out  IDX_W;  c_offset  out  OFF_W;  c_data_in  out  LINE_W
- c_tag_out  in  TAG_W;  c_data_out  in  LINE_W;  c_hit, c_dirty, c_valid, c_err  in  1 each
- mem_req_valid  out  1;  mem_req_ready  in  1;  mem_req_write  out  1
- mem_req_addr  out  ADDR_W;  mem_req_wdata  out  LINE_W
- mem_rsp_valid  in  1;  mem_rsp_data  in  LINE_W  fill data (read responses only)

Behaviour:
- Reset: rst==0 at a rising edge puts the FSM in IDLE and clears all outputs to 0. The one exception is req_ready, which is 1 from the first cycle after reset.
- Reset mid-operation aborts immediately, drops mem_req_valid and rsp_valid, and leaves array contents untouched.
- req_ready=1 only in IDLE. Acceptance latches addr, write and wdata into request registers.
- Cache outputs are read combinationally in the same cycle. A cache write commits at the clock edge.
- c_enable=0 in every state except COMP, VICT, FILL_WR and RETRY.
- c_offset is always 0. c_index and c_tag_in come from the latched address, except as noted below.
- IDLE -> ERR if req_addr[OFF_W-1:0] != 0. The array is not accessed.
- IDLE -> COMP on any other accepted request.
- COMP: enable=1, comp=1, write=req_write, data_in=wdata. A hit is c_hit&c_valid.
  - Read hit: capture c_data_out, go to RESP. Request-to-rsp_valid latency is 2 cycles.
  - Write hit: the array writes the line and sets dirty, go to RESP.
  - Miss with c_valid&c_dirty: go to VICT.
  - Other miss: go to FILL_REQ.
- VICT: enable=1, comp=0, write=0. Capture c_tag_out and c_data_out as the victim. Go to WB_REQ.
- WB_REQ: mem_req_valid=1, write=1, addr={victim_tag,index,0}, wdata=victim line. Held stable until mem_req_ready, then go to FILL_REQ. Writeback is posted; it has no response.
- FILL_REQ: mem_req_valid=1, write=0, addr={tag,index,0}. On mem_req_ready go to FILL_WAIT. mem_rsp_valid is ignored in this state.
- FILL_WAIT: wait for mem_rsp_valid, capture mem_rsp_data, go to FILL_WR. No timeout.
- FILL_WR: enable=1, comp=0, write=1, valid_in=1, data_in=fill line. The array sets tag and valid and clears dirty.
  - Read: rsp_data=fill line, go to RESP.
  - Write: go to RETRY.
- RETRY: enable=1, comp=1, write=1, data_in=wdata. Must hit; the line is written and marked dirty. Go to RESP.
- RESP and ERR: rsp_valid=1 is held until rsp_ready, then go to IDLE. In ERR, rsp_err=1 and rsp_data=0. rsp_data for writes is 0.
- A new request cannot overlap an outstanding one. req_ready returns to 1 in the cycle after the response handshake.
- mem_rsp_valid outside FILL_WAIT is ignored.

Optional Feature:
- Macro L2_STATS_EN.
- When defined, adds three 32-bit outputs: stat_hits, stat_misses, stat_writebacks.
  - Each counts at COMP hit, COMP miss, and WB_REQ handshake respectively.
  - Counters saturate at 32'hFFFFFFFF and clear on reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Write miss to clean line: req write addr 0x1000, wdata=A, memory returns F. Required: mem read at 0x1000, FILL_WR fills F, RETRY writes A. A subsequent read of 0x1000 returns A with latency 2 and no memory traffic.
- Dirty eviction: after the above, read 0x1000+(1<<13), which is the same index with a different tag. Required: mem write at 0x1000 with data A, then mem read at 0x3000. Response carries the fill data and stat_writebacks==1.
- Misaligned: read 0x1004. Required: rsp_err=1, rsp_data=0, c_enable never asserted, no mem request.
- Backpressure: hold mem_req_ready=0 for 5 cycles and rsp_ready=0 for 3 cycles. Required: mem_req_* and rsp_* are stable throughout and req_ready stays 0.
- Reset in FILL_WAIT: rst=0 for 1 cycle. Required: IDLE on the next cycle, all outputs 0 except req_ready=1. A late mem_rsp_valid is ignored.
- Read hit with rsp_ready tied 1: back-to-back reads of 0x1000 complete one every 3 cycles.
